div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40: maximum WAIT-state cycles before a divider operation is abandoned.
REQ-002 The block SHALL have one clock `clk` and a synchronous, active-high reset `reset`.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req0, req1  input  1 each  request level, held until the matching gnt is seen.
REQ-006 dvd0, dvs0, dvd1, dvs1  input  16 each  signed dividend/divisor per requester, stable while req is high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands already captured.
REQ-008 rsp_valid0, rsp_valid1  output  1 each  one-cycle response pulse.
REQ-009 rsp_quotient, rsp_remainder  output  16 each  shared signed result bus, meaningful only while a rsp_valid is high.
REQ-010 rsp_err  output  1  error flag qualified by rsp_valid (divide-by-zero or timeout).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 div_start  output  1  one-cycle start pulse to the divider.
REQ-013 div_clear  output  1  one-cycle divider reset pulse, issued on timeout.
REQ-014 div_dividend, div_divisor  output  16 each  captured operands, held from ISSUE until RESP.
REQ-015 div_quotient, div_remainder  input  16 each  divider results.
REQ-016 div_done  input  1  divider done level; low in the cycle after div_start.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req is high, pick the winner, capture its operands and owner id, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin with a last-served pointer; on simultaneous req0/req1 the requester not served last wins; after reset req0 wins a tie.
REQ-020 ISSUE: the owner's gnt pulses high for one cycle.
REQ-021 ISSUE, divisor nonzero: div_start pulses high, wait counter clears, and the FSM goes to WAIT.
REQ-022 ISSUE, divisor == 0: no div_start; result is quotient 16'h0000, remainder = dividend, rsp_err = 1; the FSM goes to RESP.
REQ-023 WAIT, div_done high: latch div_quotient/div_remainder, rsp_err = 0, go to RESP.
REQ-024 WAIT, counter reaches TIMEOUT with div_done low: pulse div_clear, result quotient 0, remainder 0, rsp_err = 1, go to RESP.
REQ-025 WAIT otherwise: increment the counter, which saturates and never wraps.
REQ-026 RESP: the owner's rsp_valid pulses for one cycle with the result on the shared bus, the last-served pointer updates to the owner, and the FSM goes to IDLE.
REQ-027 req inputs SHALL be ignored outside IDLE; a requester SHALL drop req the cycle after gnt, and a req still high in IDLE counts as a new request.
REQ-028 The block SHALL accept at most one operation in flight; minimum request-to-response latency is 3 cycles (divide-by-zero path).
REQ-029 Divider results SHALL be passed through unmodified: quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-030 gnt, rsp_valid, div_start and div_clear SHALL never be high for two consecutive cycles.
REQ-031 gnt0 and gnt1 SHALL never be high together, and rsp_valid0 and rsp_valid1 SHALL never be high together.

Reset
REQ-032 Reset SHALL force state IDLE, pointer = 1 (req0 favoured), counter 0.
REQ-033 Reset SHALL drive all outputs to 0: gnt*, rsp_valid*, rsp_*, rsp_err, busy, div_start, div_clear, div_dividend, div_divisor.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no rsp_valid; the divider is reset by the system reset, not by div_clear.

Verification
REQ-035 req0 with 100/7 -> gnt0 pulse, then exactly one div_start, then rsp_valid0 with quotient 14, remainder 2, rsp_err 0.
REQ-036 req1 with -100/7 -> rsp_valid1 with quotient -14, remainder -2; then req0 and req1 high in the same cycle -> req0 served first, req1 second.
REQ-037 req0 with 55/0 -> no div_start, rsp_valid0 with quotient 0, remainder 55, rsp_err 1, exactly 3 cycles after req0 is sampled.
REQ-038 div_done stubbed low, TIMEOUT = 8 -> div_clear pulse after 8 WAIT cycles, rsp_err 1, FSM back in IDLE, busy low.
REQ-039 reset asserted in WAIT -> next cycle all outputs 0, no rsp_valid; a following req0 with 9/3 -> quotient 3, remainder 0.
REQ-040 req0 and req1 held continuously -> grants alternate 0,1,0,1 with no double grant.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Bus bundle for div_arbiter: two requester ports, the shared response bus and
// the divider control/result port. The arbiter uses slave; the environment uses master.
interface div_arbiter_if;
    logic        req0;
    logic        req1;
    logic [15:0] dvd0;
    logic [15:0] dvs0;
    logic [15:0] dvd1;
    logic [15:0] dvs1;
    logic        gnt0;
    logic        gnt1;
    logic        rsp_valid0;
    logic        rsp_valid1;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic        rsp_err;
    logic        busy;
    logic        div_start;
    logic        div_clear;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quotient;
    logic [15:0] div_remainder;
    logic        div_done;

    modport slave (
        input  req0, req1, dvd0, dvs0, dvd1, dvs1,
        input  div_quotient, div_remainder, div_done,
        output gnt0, gnt1, rsp_valid0, rsp_valid1,
        output rsp_quotient, rsp_remainder, rsp_err, busy,
        output div_start, div_clear, div_dividend, div_divisor
    );

    modport master (
        output req0, req1, dvd0, dvs0, dvd1, dvs1,
        output div_quotient, div_remainder, div_done,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1,
        input  rsp_quotient, rsp_remainder, rsp_err, busy,
        input  div_start, div_clear, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one signed 16-bit divider between two requesters,
// with divide-by-zero bypass and a WAIT-state timeout that clears the divider.
module div_arbiter #(
    parameter int TIMEOUT = 40
) (
    input logic          clk,
    input logic          reset,
    div_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             last_served;
    logic             winner;
    logic             any_req;
    logic             div_zero;
    logic             timed_out;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      op_dividend;
    logic [15:0]      op_divisor;
    logic [15:0]      res_quotient;
    logic [15:0]      res_remainder;
    logic             res_err;

    assign any_req   = bus.req0 || bus.req1;
    assign div_zero  = (op_divisor == 16'h0000);
    assign timed_out = (wait_cnt == CNT_MAX) && !bus.div_done;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~last_served;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = div_zero ? RESP : WAIT;
            WAIT:    if (bus.div_done || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner         <= 1'b0;
            last_served   <= 1'b1;
            wait_cnt      <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= winner;
                        op_dividend <= winner ? bus.dvd1 : bus.dvd0;
                        op_divisor  <= winner ? bus.dvs1 : bus.dvs0;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    if (div_zero) begin
                        res_quotient  <= 16'h0000;
                        res_remainder <= op_dividend;
                        res_err       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.div_done) begin
                        res_quotient  <= bus.div_quotient;
                        res_remainder <= bus.div_remainder;
                        res_err       <= 1'b0;
                    end else if (wait_cnt == CNT_MAX) begin
                        res_quotient  <= 16'h0000;
                        res_remainder <= 16'h0000;
                        res_err       <= 1'b1;
                    end else begin
                        // The state exits at CNT_MAX, so the counter never wraps.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_served <= owner;
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.gnt0       = 1'b0;
        bus.gnt1       = 1'b0;
        bus.rsp_valid0 = 1'b0;
        bus.rsp_valid1 = 1'b0;
        bus.div_start  = 1'b0;
        bus.div_clear  = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.gnt0      = ~owner;
                bus.gnt1      = owner;
                bus.div_start = ~div_zero;
            end
            WAIT: begin
                bus.div_clear = timed_out;
            end
            RESP: begin
                bus.rsp_valid0 = ~owner;
                bus.rsp_valid1 = owner;
            end
            default: begin
                bus.busy = (state != IDLE);
            end
        endcase
    end

    assign bus.rsp_quotient  = res_quotient;
    assign bus.rsp_remainder = res_remainder;
    assign bus.rsp_err       = res_err;
    assign bus.div_dividend  = op_dividend;
    assign bus.div_divisor   = op_divisor;
endmodule
